alu_nbit_pipe: RTL and testbench

ALU_NBIT_PIPE -- requirements
Module: alu_nbit_pipe

---
 rtl/alu_nbit_pipe.sv | 149 ++++++++++++++
 tb/tb_alu_nbit_pipe.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_nbit_pipe.sv
// alu_nbit_pipe: two-stage pipelined N-bit ALU with a valid/ready handshake
// on both sides and a counter of results consumed downstream.
//
// Ports:
//   clk        - single clock; all state changes on the rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - operand set (A, B, opcode) is valid
//   in_ready   - block accepts an operand set this cycle (low only while stalled)
//   A, B       - WIDTH-bit unsigned operands
//   opcode     - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 EQ, 110 LT, 111 NOP
//   out_valid  - result and flags are valid
//   out_ready  - downstream accepts the result
//   result     - WIDTH-bit result
//   zero_flag  - result == 0
//   carry_flag - ADD carry-out / SUB borrow, 0 otherwise
//   ovf_flag   - two's-complement overflow of ADD/SUB, 0 otherwise
//   op_count   - results consumed since reset (wraps)
module alu_nbit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             ovf_flag,
    output logic [CNT_W-1:0] op_count
);

    // Overflow when both operands share a sign and the sum's sign differs.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Overflow when operand signs differ and the difference takes B's sign.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    logic             s1_v;
    logic             s2_v;
    logic             stall;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    logic [2:0]       op_p1;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   dif_w;
    logic [WIDTH-1:0] res_c;
    logic             carry_c;
    logic             ovf_c;

    logic [WIDTH-1:0] res_p2;
    logic             zero_p2;
    logic             carry_p2;
    logic             ovf_p2;

    // A full S2 that downstream refuses freezes the whole pipe.
    assign stall    = s2_v && !out_ready;
    assign in_ready = !stall;

    // ---- Stage 1: operand capture ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
        end else if (!stall) begin
            s1_v <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall && in_valid) begin
            a_p1  <= A;
            b_p1  <= B;
            op_p1 <= opcode;
        end
    end

    // ---- Stage 1 -> 2: combinational ALU ----
    // The extra top bit of the (WIDTH+1)-bit difference is the borrow, i.e. A < B.
    always_comb begin
        sum_w   = {1'b0, a_p1} + {1'b0, b_p1};
        dif_w   = {1'b0, a_p1} - {1'b0, b_p1};
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (op_p1)
            3'b000: begin
                res_c   = sum_w[WIDTH-1:0];
                carry_c = sum_w[WIDTH];
                ovf_c   = add_ovf(a_p1[WIDTH-1], b_p1[WIDTH-1], sum_w[WIDTH-1]);
            end
            3'b001: begin
                res_c   = dif_w[WIDTH-1:0];
                carry_c = dif_w[WIDTH];
                ovf_c   = sub_ovf(a_p1[WIDTH-1], b_p1[WIDTH-1], dif_w[WIDTH-1]);
            end
            3'b010: res_c = a_p1 & b_p1;
            3'b011: res_c = a_p1 | b_p1;
            3'b100: res_c = a_p1 ^ b_p1;
            3'b101: res_c = {{(WIDTH-1){1'b0}}, (a_p1 == b_p1)};
            3'b110: res_c = {{(WIDTH-1){1'b0}}, (a_p1 < b_p1)};
            3'b111: res_c = '0;
        endcase
    end

    // ---- Stage 2: result and flag registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v     <= 1'b0;
            res_p2   <= '0;
            zero_p2  <= 1'b0;
            carry_p2 <= 1'b0;
            ovf_p2   <= 1'b0;
        end else if (!stall) begin
            s2_v <= s1_v;
            if (s1_v) begin
                res_p2   <= res_c;
                zero_p2  <= (res_c == '0);
                carry_p2 <= carry_c;
                ovf_p2   <= ovf_c;
            end
        end
    end

    // ---- Output side: consumed-result counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (s2_v && out_ready) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

    assign out_valid  = s2_v;
    assign result     = res_p2;
    assign zero_flag  = zero_p2;
    assign carry_flag = carry_p2;
    assign ovf_flag   = ovf_p2;

endmodule

// File: tb/tb_alu_nbit_pipe.sv
// tb_alu_nbit_pipe: directed and randomised self-checking bench for alu_nbit_pipe
// (WIDTH=8, CNT_W=16). Inputs change on the falling edge; outputs are sampled
// on the falling edge, away from the active rising edge.
module tb_alu_nbit_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  opcode;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  result;
    logic        zero_flag;
    logic        carry_flag;
    logic        ovf_flag;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    alu_nbit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero_flag(zero_flag), .carry_flag(carry_flag),
        .ovf_flag(ovf_flag), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: returns {carry, ovf, zero, result[7:0]} from integer arithmetic.
    function automatic logic [10:0] model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        int ix, iy, r;
        logic c, o;
        ix = int'(x); iy = int'(y); c = 1'b0; o = 1'b0; r = 0;
        case (op)
            3'd0: begin r = (ix + iy) % 256; c = (ix + iy) > 255;
                        o = ((ix >= 128) == (iy >= 128)) && ((r >= 128) != (ix >= 128)); end
            3'd1: begin r = (ix - iy + 256) % 256; c = ix < iy;
                        o = ((ix >= 128) != (iy >= 128)) && ((r >= 128) != (ix >= 128)); end
            3'd2: r = int'(x & y);
            3'd3: r = int'(x | y);
            3'd4: r = int'(x ^ y);
            3'd5: r = (ix == iy) ? 1 : 0;
            3'd6: r = (ix < iy) ? 1 : 0;
            default: r = 0;
        endcase
        return {c, o, (r == 0), 8'(r)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; a = 8'hF0; b = 8'h20; opcode = 3'd0; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || result !== 8'h00 || zero_flag !== 1'b0 || carry_flag !== 1'b0 ||
            ovf_flag !== 1'b0 || op_count !== 16'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got vld=%b res=%h z=%b c=%b o=%b cnt=%0d rdy=%b, want 0 00 0 0 0 0 1",
                     out_valid, result, zero_flag, carry_flag, ovf_flag, op_count, in_ready);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        exp_cnt = 0;
    endtask

    // One isolated op with out_ready held high; checks the 2-cycle latency and all outputs.
    task automatic do_op(input string nm, input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] er, input logic ec, input logic eo, input logic ez);
        @(negedge clk);
        in_valid = 1'b1; opcode = op; a = x; b = y; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = 8'h5A; b = 8'hA5; opcode = 3'd4;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_early: out_valid=%b one edge after accept, want 0", nm, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || result !== er || carry_flag !== ec || ovf_flag !== eo || zero_flag !== ez) begin
            errors++;
            $display("FAIL %s: got vld=%b res=%h c=%b o=%b z=%b, want 1 %h %b %b %b",
                     nm, out_valid, result, carry_flag, ovf_flag, zero_flag, er, ec, eo, ez);
        end
        exp_cnt++;
    endtask

    task automatic test_arith();
        do_op("add_f0_20", 3'd0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0);
        do_op("add_7f_01", 3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        do_op("sub_05_07", 3'd1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0);
        do_op("sub_80_01", 3'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        do_op("add_80_80", 3'd0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1);
        do_op("sub_33_33", 3'd1, 8'h33, 8'h33, 8'h00, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (op_count !== 16'(exp_cnt) || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL arith_count: got cnt=%0d vld=%b, want %0d 0", op_count, out_valid, exp_cnt);
        end
    endtask

    task automatic test_logic();
        do_op("eq_3c_3c",  3'd5, 8'h3C, 8'h3C, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op("eq_3c_3d",  3'd5, 8'h3C, 8'h3D, 8'h00, 1'b0, 1'b0, 1'b1);
        do_op("lt_03_80",  3'd6, 8'h03, 8'h80, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op("lt_80_03",  3'd6, 8'h80, 8'h03, 8'h00, 1'b0, 1'b0, 1'b1);
        do_op("nop_ff_ff", 3'd7, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
        do_op("or_0f_f0",  3'd3, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0);
        do_op("xor_aa_aa", 3'd4, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b1);
        do_op("and_f0_3c", 3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; opcode = 3'd0; a = 8'h01; b = 8'h02;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready_s2_empty: in_ready=%b, want 1", in_ready);
        end
        opcode = 3'd0; a = 8'h10; b = 8'h20;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_ready_s2_full: in_ready=%b, want 0", in_ready);
        end
        opcode = 3'd4; a = 8'h0F; b = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || result !== 8'h03 || carry_flag !== 1'b0 || zero_flag !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_hold%0d: got vld=%b res=%h c=%b z=%b rdy=%b, want 1 03 0 0 0",
                         i, out_valid, result, carry_flag, zero_flag, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || result !== 8'h03) begin
            errors++; $display("FAIL b2b_release: got rdy=%b res=%h, want 1 03", in_ready, result);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h30) begin
            errors++; $display("FAIL b2b_second: got vld=%b res=%h, want 1 30", out_valid, result);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || result !== 8'hF0) begin
            errors++; $display("FAIL b2b_third: got vld=%b res=%h, want 1 f0", out_valid, result);
        end
        @(negedge clk);
        exp_cnt += 3;
        checks++;
        if (out_valid !== 1'b0 || op_count !== 16'(exp_cnt)) begin
            errors++; $display("FAIL b2b_drain: got vld=%b cnt=%0d, want 0 %0d", out_valid, op_count, exp_cnt);
        end
    endtask

    task automatic test_random();
        logic [10:0] q[$];
        logic [10:0] cur, prev, exp;
        logic        hold;
        int          acc, cyc;
        acc = 0; cyc = 0; hold = 1'b0; prev = '0;
        while ((acc < 1000 || q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            cur = {carry_flag, ovf_flag, zero_flag, result};
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || cur !== prev) begin
                    errors++;
                    $display("FAIL rnd_stable: cyc %0d got vld=%b out=%h, want 1 %h", cyc, out_valid, cur, prev);
                end
            end
            if (acc < 1000) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 7);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            a = 8'($urandom); b = 8'($urandom); opcode = 3'($urandom_range(0, 7));
            #1;
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL rnd_in_ready: cyc %0d got %b, want %b", cyc, in_ready, !(out_valid && !out_ready));
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra: cyc %0d got result %h, want none", cyc, result);
                end else begin
                    exp = q.pop_front();
                    if (cur !== exp) begin
                        errors++; $display("FAIL rnd_result: cyc %0d got %h, want %h", cyc, cur, exp);
                    end
                end
                exp_cnt++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(opcode, a, b));
                acc++;
            end
            hold = out_valid && !out_ready;
            prev = cur;
        end
        checks++;
        if (cyc >= 20000) begin
            errors++; $display("FAIL rnd_timeout: got %0d accepted %0d pending, want 1000 0", acc, q.size());
        end
        @(negedge clk);
        checks++;
        if (op_count !== 16'(exp_cnt) || out_valid !== 1'b0) begin
            errors++; $display("FAIL rnd_count: got cnt=%0d vld=%b, want %0d 0", op_count, out_valid, exp_cnt);
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; opcode = 3'd0; a = 8'h01; b = 8'h01;
        @(negedge clk);
        a = 8'h02; b = 8'h02;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_full: got vld=%b rdy=%b, want 1 0", out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || op_count !== 16'd0 || result !== 8'h00 || in_ready !== 1'b1 ||
            zero_flag !== 1'b0 || carry_flag !== 1'b0 || ovf_flag !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: got vld=%b cnt=%0d res=%h rdy=%b z=%b c=%b o=%b, want 0 0 00 1 0 0 0",
                     out_valid, op_count, result, in_ready, zero_flag, carry_flag, ovf_flag);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; opcode = 3'd1; a = 8'h09; b = 8'h04;
        exp_cnt = 0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_stale: out_valid=%b after release, want 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h05 || carry_flag !== 1'b0) begin
            errors++; $display("FAIL midrst_first_op: got vld=%b res=%h c=%b, want 1 05 0", out_valid, result, carry_flag);
        end
        exp_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL midrst_quiet%0d: out_valid=%b, want 0", i, out_valid);
            end
        end
        checks++;
        if (op_count !== 16'(exp_cnt)) begin
            errors++; $display("FAIL midrst_count: got %0d, want %0d", op_count, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
